// File: rtl/jk_register_bank_if.sv
// Signal bundle for jk_register_bank: JK/enable/load stimulus in, cell state and change status out.
// There is no handshake: the master drives inputs every cycle and the slave updates outputs every clk edge.
interface jk_register_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             en;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             load;
    logic [WIDTH-1:0] d;
    logic             clr_cnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic             changed;
    logic [CNT_W-1:0] change_cnt;

    modport master (
        output en, j, k, load, d, clr_cnt,
        input  q, q_n, changed, change_cnt
    );

    modport slave (
        input  en, j, k, load, d, clr_cnt,
        output q, q_n, changed, change_cnt
    );
endinterface

// File: rtl/jk_register_bank.sv
// Bank of WIDTH independent JK cells with optional j/k/en synchroniser,
// parallel load, registered change flag and saturating change counter.
module jk_register_bank #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RST_VAL     = {WIDTH{1'b0}},
    parameter int               SYNC_STAGES = 0,
    parameter int               CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    jk_register_bank_if.slave bus
);

    logic [WIDTH-1:0] j_p;
    logic [WIDTH-1:0] k_p;
    logic             en_p;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign j_p  = bus.j;
            assign k_p  = bus.k;
            assign en_p = bus.en;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0][WIDTH-1:0] j_pipe_q;
            logic [SYNC_STAGES-1:0][WIDTH-1:0] j_pipe_d;
            logic [SYNC_STAGES-1:0][WIDTH-1:0] k_pipe_q;
            logic [SYNC_STAGES-1:0][WIDTH-1:0] k_pipe_d;
            logic [SYNC_STAGES-1:0]            en_pipe_q;
            logic [SYNC_STAGES-1:0]            en_pipe_d;

            always_comb begin
                j_pipe_d[0]  = bus.j;
                k_pipe_d[0]  = bus.k;
                en_pipe_d[0] = bus.en;
                for (int s = 1; s < SYNC_STAGES; s++) begin
                    j_pipe_d[s]  = j_pipe_q[s-1];
                    k_pipe_d[s]  = k_pipe_q[s-1];
                    en_pipe_d[s] = en_pipe_q[s-1];
                end
            end

            // Clearing the pipe on reset discards any command still in flight.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    j_pipe_q  <= '0;
                    k_pipe_q  <= '0;
                    en_pipe_q <= '0;
                end else begin
                    j_pipe_q  <= j_pipe_d;
                    k_pipe_q  <= k_pipe_d;
                    en_pipe_q <= en_pipe_d;
                end
            end

            assign j_p  = j_pipe_q[SYNC_STAGES-1];
            assign k_p  = k_pipe_q[SYNC_STAGES-1];
            assign en_p = en_pipe_q[SYNC_STAGES-1];
        end
    endgenerate

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             changed_q;
    logic             changed_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        q_d = q_q;
        if (bus.load) begin
            q_d = bus.d;
        end else if (en_p) begin
            // JK characteristic: 00 hold, 01 clear, 10 set, 11 toggle.
            q_d = (j_p & ~q_q) | (~k_p & q_q);
        end
    end

    always_comb begin
        changed_d = (q_d != q_q);
        cnt_d     = cnt_q;
        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (changed_d && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q       <= RST_VAL;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            q_q       <= q_d;
            changed_q <= changed_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.q          = q_q;
    assign bus.q_n        = ~q_q;
    assign bus.changed    = changed_q;
    assign bus.change_cnt = cnt_q;

endmodule

// File: doc/jk_register_bank.md
Name: jk_register_bank

Overview:
- Parametrised, multi-bit successor to the single-bit JK flip-flop: WIDTH independent JK cells sharing one clock, reset, clock enable and parallel-load path.
- Adds an optional input synchroniser pipeline on J/K/en, a per-edge change flag, and a saturating change-event counter for status/debug logic.
- Used wherever a bank of set/reset/toggle control bits is needed, such as mode latches and status flags.

Parameters:
- WIDTH, 8, number of JK cells (1..64)
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- SYNC_STAGES, 0, register stages on j/k/en before the cells (0..3)
- CNT_W, 16, width of change_cnt (2..32)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  cell enable; delayed with j/k through the sync pipeline
- j  in  WIDTH  per-bit J (set)
- k  in  WIDTH  per-bit K (reset)
- load  in  1  synchronous parallel load, not pipelined
- d  in  WIDTH  parallel load data
- clr_cnt  in  1  synchronous clear of change_cnt
- q  out  WIDTH  cell outputs
- q_n  out  WIDTH  bitwise ~q, combinational
- changed  out  1  high for the cycle in which q holds a value different from the previous cycle
- change_cnt  out  CNT_W  saturating count of edges where q changed

Behaviour:
- Reset (async, any time, including mid-pipeline):
  - q=RST_VAL, changed=0, change_cnt=0.
  - All sync pipeline registers (j, k, en) clear to 0.
  - The first post-reset edge with rst=0 is a normal edge.
- Sync pipeline:
  - j_p/k_p/en_p are j/k/en delayed by exactly SYNC_STAGES clk edges.
  - SYNC_STAGES=0 means combinational pass-through.
  - Input-to-q latency is SYNC_STAGES+1 edges.
- Next-state per bit i, priority rst > load > en_p:
  - load=1: q_next = d (load ignores en and the pipelined j/k).
  - load=0, en_p=0: hold.
  - load=0, en_p=1, {j_p[i],k_p[i]}=00: hold.
  - 01: 0.
  - 10: 1.
  - 11: ~q[i].
- Bits are fully independent; no cross-bit interaction.
- changed: registered, = (q_next != q) at the edge; updates with q, so it is visible in the same cycle as the new q. Load of an identical value leaves changed=0.
- change_cnt, at each edge:
  - clr_cnt=1: 0. Clear wins over a simultaneous change.
  - else if q_next != q and change_cnt != all-ones: +1.
  - else hold. Saturates at 2^CNT_W-1 with no wrap.
- One edge changing several bits counts once.
- q_n always equals ~q, including during reset.
- No X propagation: every register has a reset value.

Test Plan:
- WIDTH=8, SYNC_STAGES=0, RST_VAL=8'hA5: assert rst mid-cycle -> q=A5 immediately, q_n=5A, changed=0, cnt=0. Deassert, en=1, j=0F, k=F0 -> next edge q=0F, changed=1, cnt=1.
- Toggle: q=0F, en=1, j=k=FF for 3 edges -> q=F0, 0F, F0; changed high each cycle; cnt +3. Then j=k=00 -> q holds, changed=0.
- Priority: load=1, d=3C, en=1, j=k=FF on the same edge -> q=3C. Then load=0, en=0, j=FF -> q stays 3C, changed=0. Load d=3C again -> changed=0, cnt unchanged.
- SYNC_STAGES=2: j=01, k=00, en=1 presented for one cycle from q=00 -> q becomes 01 on the 3rd edge, not earlier. Async rst asserted after the 1st edge -> q never sets.
- CNT_W=2: toggle bit0 for 5 edges -> cnt 1,2,3,3,3. Then clr_cnt=1 with a simultaneous toggle -> cnt=0 and q toggled. Next toggle -> cnt=1.
- Randomised per-bit j/k/en/load vs. reference model for 10k cycles, WIDTH=1 and WIDTH=64 -> q, changed and change_cnt match every cycle.
